clock_divider: RTL and testbench



---
 rtl/clock_divider_pkg.sv | 12 +
 rtl/clock_divider.sv | 60 ++++++
 tb/tb_clock_divider.sv | 125 ++++++++++++
 3 files changed

// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the integer clock divider.
package clock_divider_pkg;

  localparam int unsigned DIV_MIN = 2;
  localparam int unsigned DIV_MAX = 65535;

  // Number of input cycles the divided clock spends high.
  function automatic int unsigned high_cycles(input int unsigned n);
    return n / 2;
  endfunction

endpackage

// File: rtl/clock_divider.sv
// Integer clock divider: clk_output has a period of DIVIDE input cycles with a
// high phase of floor(DIVIDE/2) cycles, and tick pulses once per period.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int unsigned DIVIDE = 12,
  parameter int unsigned CNT_W  = $clog2(DIVIDE)
) (
  input  logic clk_12mhz,
  input  logic rst,
  input  logic en,
  output logic clk_output,
  output logic tick
);

  if (DIVIDE < DIV_MIN || DIVIDE > DIV_MAX) begin : g_bad_divide
    $error("clock_divider: DIVIDE out of range 2..65535");
  end

  localparam int unsigned      HIGH     = high_cycles(DIVIDE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDE - 1);
  localparam logic [CNT_W-1:0] CNT_FALL = CNT_W'(HIGH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  // Rise on wrap, fall when leaving cnt == HIGH-1; the two never coincide.
  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        clk_d  = 1'b1;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_FALL) clk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_output = clk_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_clock_divider.sv
// Randomized bench for clock_divider at DIVIDE = 12, 5 and 2 against an
// enabled-edge-count reference model.
module tb_clock_divider;

  localparam int unsigned NV [3] = '{12, 5, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [2:0] co, tk;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clock_divider #(.DIVIDE(12)) u_d12 (.clk_12mhz(clk), .rst(rst), .en(en), .clk_output(co[0]), .tick(tk[0]));
  clock_divider #(.DIVIDE(5))  u_d5  (.clk_12mhz(clk), .rst(rst), .en(en), .clk_output(co[1]), .tick(tk[1]));
  clock_divider #(.DIVIDE(2))  u_d2  (.clk_12mhz(clk), .rst(rst), .en(en), .clk_output(co[2]), .tick(tk[2]));

  // Model: e = enabled edges since reset; the output is high during the first
  // floor(N/2) cycles of every period after the first complete one.
  int unsigned e [3];
  bit          mtick [3];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        e[i]     = 0;
        mtick[i] = 1'b0;
      end else if (en) begin
        e[i]     = e[i] + 1;
        mtick[i] = (e[i] % NV[i]) == 0;
      end else begin
        mtick[i] = 1'b0;
      end
    end
  end

  function automatic bit exp_clk(input int i);
    return (e[i] >= NV[i]) && ((e[i] % NV[i]) < (NV[i] / 2));
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("clk_output N=%0d", NV[i]), int'(co[i]), int'(exp_clk(i)));
      chk($sformatf("tick N=%0d", NV[i]), int'(tk[i]), int'(mtick[i]));
    end
  endtask

  initial begin
    int  rises, ticks;
    bit  found;
    logic prev;

    // Reset state
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    rst = 1'b0;
    en  = 1'b1;

    // Run 15 enabled edges (cnt=3 at N=12), freeze 7 cycles, resume.
    repeat (15) begin @(negedge clk); check_all(); end
    en = 1'b0;
    repeat (7) begin
      @(negedge clk);
      check_all();
      chk("freeze clk high", int'(co[0]), 1);
      chk("freeze tick low", int'(tk[0]), 0);
    end
    en = 1'b1;
    repeat (40) begin @(negedge clk); check_all(); end

    // Random enable pattern
    repeat (600) begin
      @(negedge clk);
      check_all();
      en = ($urandom_range(0, 3) != 0);
    end

    // Async reset while N=12 output is high at cnt=2
    en    = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      check_all();
      if (e[0] >= 12 && (e[0] % 12) == 2) found = 1'b1;
    end
    chk("async_rst find cnt2", int'(found), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst clk_output", int'(co[0]), 0);
    chk("async_rst tick", int'(tk[0]), 0);
    repeat (3) begin @(negedge clk); check_all(); end
    rst = 1'b0;

    // Long run at en=1
    rises = 0;
    ticks = 0;
    prev  = co[0];
    repeat (10000) begin
      @(negedge clk);
      check_all();
      if (co[0] && !prev) rises++;
      if (tk[0]) ticks++;
      prev = co[0];
    end
    chk("long_run rises", rises, 10000 / 12);
    chk("long_run ticks", ticks, 10000 / 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
